// File: rtl/kronecker_stream_ctrl.sv
// Feeds a latched 2-share AES state byte-by-byte into the masked Kronecker-delta unit,
// supplies LFSR randomness, and gathers the 16 shared delta bits for downstream use.
// state | meaning: IDLE wait for start; FEED stream bytes 0..15; DRAIN await last capture; DONE one-cycle done pulse
module kronecker_stream_ctrl #(
  parameter int          KLAT      = 3,
  parameter logic [31:0] LFSR_POLY = 32'h80200003
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] state_sh0,
  input  logic [127:0] state_sh1,
  input  logic         seed_ld,
  input  logic [31:0]  seed,
  output logic [15:0]  k_inp,
  output logic [2:0]   k_rand,
  input  logic [1:0]   k_z,
  output logic         busy,
  output logic         done,
  output logic [15:0]  z_sh0,
  output logic [15:0]  z_sh1
);

  typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN, S_DONE} state_t;

  state_t          r_state;
  logic [127:0]    r_sh0;
  logic [127:0]    r_sh1;
  logic [4:0]      r_feed_idx;
  logic            r_kvld;
  logic [KLAT-1:0] r_vpipe;
  logic [4:0]      r_cap_cnt;
  logic [31:0]     r_lfsr;

  logic [31:0]     w_lfsr_step;
  logic [6:0]      w_base;
  logic            w_tail;
  logic [3:0]      w_cap_idx;

  assign w_lfsr_step = (r_lfsr >> 1) ^ (r_lfsr[0] ? LFSR_POLY : 32'h0);
  assign w_base      = {r_feed_idx[3:0], 3'b000};
  assign w_tail      = r_vpipe[KLAT-1];
  assign w_cap_idx   = r_cap_cnt[3:0];
  assign k_rand      = r_lfsr[2:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_sh0      <= '0;
      r_sh1      <= '0;
      r_feed_idx <= '0;
      r_kvld     <= 1'b0;
      r_vpipe    <= '0;
      r_cap_cnt  <= '0;
      r_lfsr     <= 32'h1;
      k_inp      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      z_sh0      <= '0;
      z_sh1      <= '0;
    end else begin
      // A zero seed would lock the LFSR, so it is replaced by 1.
      r_lfsr  <= seed_ld ? ((seed == 32'h0) ? 32'h1 : seed) : w_lfsr_step;
      r_vpipe <= (r_vpipe << 1) | KLAT'(r_kvld);
      done    <= 1'b0;

      if (w_tail) begin
        z_sh0[w_cap_idx] <= k_z[1];
        z_sh1[w_cap_idx] <= k_z[0];
        r_cap_cnt        <= r_cap_cnt + 5'd1;
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sh0      <= state_sh0;
            r_sh1      <= state_sh1;
            k_inp      <= {state_sh1[7:0], state_sh0[7:0]};
            r_kvld     <= 1'b1;
            r_feed_idx <= 5'd1;
            r_cap_cnt  <= '0;
            z_sh0      <= '0;
            z_sh1      <= '0;
            busy       <= 1'b1;
            r_state    <= S_FEED;
          end
        end
        S_FEED: begin
          if (r_feed_idx == 5'd16) begin
            k_inp   <= '0;
            r_kvld  <= 1'b0;
            r_state <= S_DRAIN;
          end else begin
            k_inp      <= {r_sh1[w_base +: 8], r_sh0[w_base +: 8]};
            r_feed_idx <= r_feed_idx + 5'd1;
          end
        end
        S_DRAIN: begin
          // Done rises on the same edge that captures byte 15.
          if (w_tail && (r_cap_cnt == 5'd15)) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
